// File: rtl/seq_divider_pkg.sv
// Shared types and width constants for the iterative restoring divider.
package seq_divider_pkg;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to represent DIVIDEND_W iterations.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module seq_divider_div_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   pr,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_next,
  output logic                 q_bit
);

  // The top bit of pr is zero while pr < divisor, but the full-width shift keeps
  // the step correct in isolation and leaves no unused input bits.
  always_comb begin
    q_bit   = ({pr, dvd_bit} >= {2'b00, divisor});
    pr_next = (DIVISOR_W + 1)'(q_bit ? ({pr, dvd_bit} - {2'b00, divisor}) : {pr, dvd_bit});
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, fixed latency of DIVIDEND_W+1 cycles.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid_in,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic [1:0]            fsm_state
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);

  state_t                state;
  state_t                state_next;
  logic                  accept;
  logic                  last_iter;
  logic [CNT_W-1:0]      count;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVIDEND_W-1:0] shreg;
  logic [DIVISOR_W:0]    pr;
  logic [DIVISOR_W:0]    pr_next;
  logic                  q_bit;
  logic                  zero_flag;
  logic [DIVISOR_W-1:0]  dvd_low;

  // Handshake: an operation is taken on a rising edge where valid_in && ready_out.
  // ready_out depends on state only; valid_out is a one-cycle pulse in DONE and
  // the result registers hold until the next completion.
  assign ready_out = (state == IDLE) || (state == DONE);
  assign valid_out = (state == DONE);
  assign accept    = valid_in && ready_out;
  assign last_iter = (count == CNT_W'(DIVIDEND_W - 1));
  assign fsm_state = state;

  seq_divider_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr      (pr),
    .dvd_bit (shreg[DIVIDEND_W-1]),
    .divisor (divisor_q),
    .pr_next (pr_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = BUSY;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    state_next = valid_in ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      divisor_q   <= '0;
      shreg       <= '0;
      pr          <= '0;
      zero_flag   <= 1'b0;
      dvd_low     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count     <= '0;
      divisor_q <= divisor;
      shreg     <= dividend;
      pr        <= '0;
      zero_flag <= (divisor == '0);
      dvd_low   <= dividend[DIVISOR_W-1:0];
    end else if (state == BUSY) begin
      // Quotient bits fill the shift register from the right as dividend bits leave it.
      shreg <= {shreg[DIVIDEND_W-2:0], q_bit};
      pr    <= pr_next;
      count <= count + CNT_W'(1);
      if (last_iter) begin
        quotient    <= zero_flag ? '1 : {shreg[DIVIDEND_W-2:0], q_bit};
        remainder   <= zero_flag ? dvd_low : pr_next[DIVISOR_W-1:0];
        div_by_zero <= zero_flag;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int DW    = 32;
  localparam int SW    = 16;
  localparam int LAT   = DW + 1;
  localparam int EXP_W = DW + SW + 1 + 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [SW-1:0] divisor = '0;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic [1:0]    fsm_state;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Each entry: {quotient, remainder, div_by_zero, expected valid_out cycle}
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;

  seq_divider dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .valid_in    (valid_in),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready_out   (ready_out),
    .valid_out   (valid_out),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] q, input logic [SW-1:0] r,
                          input logic dz, input int at);
    exp_q.push_back({q, r, dz, 32'(at)});
  endtask

  // Reference: plain integer division, with the documented divide-by-zero result.
  task automatic push_ref(input logic [DW-1:0] a, input logic [SW-1:0] b, input int at);
    logic [DW-1:0] q;
    logic [DW-1:0] r32;
    if (b == '0) begin
      q   = '1;
      r32 = a & 32'h0000_FFFF;
      push_exp(q, r32[SW-1:0], 1'b1, at);
    end else begin
      q   = a / b;
      r32 = a % b;
      push_exp(q, r32[SW-1:0], 1'b0, at);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (reset_n && valid_out) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("quotient",    quotient,    e[EXP_W-1 -: DW]);
        check("remainder",   remainder,   e[SW+32 -: SW]);
        check("div_by_zero", div_by_zero, e[32]);
        check("latency",     cyc,         e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [DW-1:0] a, input logic [SW-1:0] b,
                       input bit keep, output int acc);
    int guard;
    guard = 0;
    @(negedge clock);
    while (!ready_out && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    acc = cyc;
    if (!ready_out) begin
      check("ready_timeout", ready_out, 1);
      return;
    end
    valid_in = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    if (!keep) valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clock);
      guard++;
    end
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc2;
    int seen;
    logic [DW-1:0] a32;
    logic [DW-1:0] b32;
    logic [DW-1:0] c32;

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready",  ready_out,   1);
    check("rst_valid",  valid_out,   0);
    check("rst_q",      quotient,    0);
    check("rst_r",      remainder,   0);
    check("rst_dz",     div_by_zero, 0);
    check("rst_state",  fsm_state,   0);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic operation with busy-window and hold checks
    issue(32'd100, 16'd7, 1'b0, acc);
    push_ref(32'd100, 16'd7, acc + LAT);
    seen = 0;
    for (int i = 1; i <= DW; i++) begin
      @(negedge clock);
      if (ready_out) seen++;
    end
    check("ready_busy", seen, 0);
    @(negedge clock);
    #1;
    check("ready_done", ready_out, 1);
    check("valid_done", valid_out, 1);
    wait_drain();
    repeat (5) @(negedge clock);
    check("hold_q",     quotient,  32'd14);
    check("hold_r",     remainder, 16'd2);
    check("hold_valid", valid_out, 0);

    // Extremes
    issue(32'hFFFF_FFFF, 16'hFFFF, 1'b0, acc);
    push_exp(32'h0001_0001, 16'h0, 1'b0, acc + LAT);
    issue(32'd5, 16'd9, 1'b0, acc);
    push_exp(32'd0, 16'd5, 1'b0, acc + LAT);
    issue(32'd0, 16'd3, 1'b0, acc);
    push_exp(32'd0, 16'd0, 1'b0, acc + LAT);
    wait_drain();

    // Divide by zero, then a normal op clears the flag
    issue(32'h1234_5678, 16'd0, 1'b0, acc);
    push_exp(32'hFFFF_FFFF, 16'h5678, 1'b1, acc + LAT);
    wait_drain();
    check("dz_flag", div_by_zero, 1);
    issue(32'd10, 16'd3, 1'b0, acc);
    push_exp(32'd3, 16'd1, 1'b0, acc + LAT);
    wait_drain();
    check("dz_cleared", div_by_zero, 0);

    // Back-to-back with valid_in held high
    issue(32'd100, 16'd7, 1'b1, acc);
    push_exp(32'd14, 16'd2, 1'b0, acc + LAT);
    dividend = 32'd1000;
    divisor  = 16'd13;
    issue(32'd1000, 16'd13, 1'b0, acc2);
    check("b2b_accept", acc2, acc + LAT);
    push_exp(32'd76, 16'd12, 1'b0, acc2 + LAT);
    wait_drain();

    // Random valid_in pulses while busy must be ignored
    issue(32'd50000, 16'd123, 1'b0, acc);
    push_ref(32'd50000, 16'd123, acc + LAT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      valid_in = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = 16'($urandom);
    end
    @(negedge clock);
    valid_in = 1'b0;
    wait_drain();

    // Reset mid-operation
    issue(32'd100, 16'd7, 1'b0, acc);
    while (cyc < acc + 10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_q",     quotient,    0);
    check("midrst_r",     remainder,   0);
    check("midrst_dz",    div_by_zero, 0);
    check("midrst_ready", ready_out,   1);
    check("midrst_valid", valid_out,   0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (valid_out) seen++;
    end
    check("midrst_no_valid", seen, 0);
    issue(32'd9, 16'd2, 1'b0, acc);
    push_exp(32'd4, 16'd1, 1'b0, acc + LAT);
    wait_drain();

    // Round trip: (a*b + c) / b == a remainder c
    for (int i = 0; i < 1000; i++) begin
      a32 = 32'($urandom_range(1, 65535));
      b32 = 32'($urandom_range(1, 65535));
      c32 = (i % 2 == 1) ? 32'($urandom_range(0, int'(b32) - 1)) : 32'd0;
      issue(a32 * b32 + c32, b32[SW-1:0], 1'b0, acc);
      push_exp(a32, c32[SW-1:0], 1'b0, acc + LAT);
    end
    wait_drain();

    // Fully random operands, including some zero divisors
    for (int i = 0; i < 200; i++) begin
      a32 = $urandom;
      b32 = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 65535));
      issue(a32, b32[SW-1:0], 1'b0, acc);
      push_ref(a32, b32[SW-1:0], acc + LAT);
    end
    wait_drain();

    report();
    $finish;
  end

  initial begin
    #5_000_000;
    check("watchdog", 0, 1);
    report();
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider, the inverse of the pipelined 16x16=32 multiplier: 32-bit dividend / 16-bit divisor gives a 32-bit quotient and a 16-bit remainder.
- Computes one quotient bit per cycle with a fixed, data-independent latency, so the static scheduler can plan around it like the multiplier.
- Sits beside the multiplier in the ALU custom-function path; uses the same valid-pulse style plus a ready signal, because it is not pipelined.

Parameters:
- DIVIDEND_W, 32, dividend and quotient width.
- DIVISOR_W, 16, divisor and remainder width; must be <= DIVIDEND_W.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  operands valid; accepted when valid_in && ready_out at a rising edge.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- ready_out  output  1  block can accept an operation this cycle.
- valid_out  output  1  one-cycle pulse: quotient/remainder/div_by_zero are valid.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  set with the result when divisor was 0.

Behaviour:
- Clock and reset: one clock, clock. Reset is reset_n, asynchronous, active-low.
- Reset values:
  - state=IDLE, so ready_out=1.
  - valid_out=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Inputs have no effect while reset_n is low.
- States: IDLE, BUSY, DONE.
- ready_out = (state==IDLE) || (state==DONE). It is combinational from state only, with no path from valid_in.
- valid_out = (state==DONE), registered.
- Accept edge (valid_in && ready_out):
  - Latch the divisor.
  - Load a shift register with the dividend.
  - Clear the partial remainder (DIVISOR_W+1 bits) and the counter.
  - Record zero-flag = (divisor==0).
  - Go to BUSY.
- BUSY, each edge:
  - pr' = {pr[DIVISOR_W-1:0], dividend_msb}; the shift register shifts left.
  - If pr' >= {1'b0, divisor}: pr = pr' - divisor and shift quotient bit 1 in. Otherwise pr = pr' and shift 0 in.
  - counter increments.
  - After the DIVIDEND_W-th iteration, the final quotient and remainder are written to the output registers and the state goes to DONE.
- DONE lasts exactly one cycle.
  - With an accept on that edge, go to BUSY (back-to-back).
  - Otherwise go to IDLE.
- Latency: valid_in sampled at the accept edge (cycle 0) gives valid_out high in cycle DIVIDEND_W+1 (33 by default).
- Maximum issue rate: one operation per DIVIDEND_W+1 cycles.
- Divide by zero: quotient = all ones, remainder = dividend[DIVISOR_W-1:0], div_by_zero=1. Latency is the same (the iteration still runs; the override is applied when the outputs are written).
- div_by_zero is 0 for non-zero divisors.
- Output hold:
  - quotient, remainder and div_by_zero hold their last value until the next completion.
  - They are not cleared when valid_out falls.
- valid_in while BUSY (ready_out=0) is ignored and not queued. The upstream scheduler guarantees spacing.
- reset_n asserted mid-operation:
  - Immediately returns to IDLE and clears the outputs.
  - The aborted operation never produces valid_out.
- Invariant: pr < divisor after every step (divisor != 0). The subtract needs DIVISOR_W+1 bits, so no overflow.

Decomposition:
- Package seq_divider_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - default width constants;
  - the counter width, $clog2(DIVIDEND_W+1).
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: pr, next dividend bit, divisor.
  - Outputs: new pr and the quotient bit.
  - Allows later unrolling to radix-4 by instantiating two in series.

Test Plan:
- Basic: dividend=100, divisor=7, accepted at cycle 0 → valid_out high only in cycle 33, quotient=14, remainder=2, div_by_zero=0; ready_out=0 in cycles 1..32.
- Extremes: 0xFFFFFFFF/0xFFFF → quotient=0x00010001, remainder=0. Then 5/9 → quotient=0, remainder=5. Then 0/3 → quotient=0, remainder=0.
- Divide by zero: 0x12345678/0 → cycle 33: quotient=0xFFFFFFFF, remainder=0x5678, div_by_zero=1. Next op 10/3 → q=3, r=1, div_by_zero=0.
- Back-to-back: valid_in held high with ops 100/7 then 1000/13.
  - Second op is accepted in the DONE cycle (33).
  - Results: 14 r2 at cycle 33, 76 r12 at cycle 66.
  - valid_in pulses during BUSY produce no extra results.
- Reset mid-op: start 100/7, drop reset_n in cycle 10 for 2 cycles → outputs 0 and ready_out=1 immediately. No valid_out in the following 40 cycles. A new op 9/2 then gives 4 r1 at 33 cycles after its accept.
- Round-trip: 1000 random non-zero 16-bit a, b; divide a*b (multiplier reference model) by b → quotient=a, remainder=0. Random c < b added to the dividend → remainder=c.
